seg_add_tree: RTL and testbench
===============================

// Module: seg_add_tree
// PURPOSE
//  Parametrised, pipelined, segmented signed fixed-point adder tree for the softmax-approx datapath.
//  Sums N_IN Qx.FRAC lanes; i_length_mode selects segment length N_IN>>mode; one sum per segment.
//  Adds per-segment overflow flags, an i_en stall and an aligned sideband bypass. Feeds the normaliser.
// PARAMETERS
//  N_IN     64  number of input lanes; power of 2, >= SEG_MIN
//  DW       16  lane/sum width, two's complement
//  FRAC     10  fractional bits (Q6.10 at default); informational, no rescaling done
//  SEG_MIN  16  shortest segment; power of 2
//  BYP_W    N_IN*DW  width of the sideband bypass bus
//  (derived) LOG2N=$clog2(N_IN); MODE_MAX=LOG2N-$clog2(SEG_MIN); NSEG=N_IN/SEG_MIN; MW=$clog2(MODE_MAX+1) (min 1); LAT=LOG2N+2
// PORTS
//  i_clk          in   1        clock, rising edge
//  i_rst          in   1        synchronous reset, active-low
//  i_en           in   1        pipeline advance; 0 freezes every stage
//  i_valid        in   1        input sample valid
//  i_length_mode  in   MW       0: 1 seg of N_IN; m: 2^m segs of N_IN>>m
//  i_in1_flat     in   N_IN*DW  summed lanes, lane k at [k*DW+:DW]
//  i_in0_flat     in   BYP_W    sideband, carried unmodified
//  o_valid        out  1        output sample valid
//  o_length_mode  out  MW       mode of the output sample
//  o_sum_flat     out  NSEG*DW  segment k sum at [k*DW+:DW]; lanes >= 2^mode are 0
//  o_ovf          out  NSEG     per-segment overflow (exact sum outside DW range)
//  o_in0_byp      out  BYP_W    sideband aligned with o_valid
// BEHAVIOUR
//  - Reset (i_rst==0 at posedge): all pipeline regs, o_valid, o_length_mode, o_sum_flat, o_ovf, o_in0_byp -> 0.
//    Reset wins over i_en; samples in flight are discarded, no o_valid afterwards.
//  - Stage 0 registers inputs; stages 1..LOG2N each add adjacent pairs; final stage selects level
//    LOG2N-mode, saturates/wraps, registers outputs. Latency LAT cycles of i_en==1 (64 lanes: 8).
//  - i_en==0: no register changes, outputs hold. Valid, mode, sideband shift in lock-step with data.
//  - Fully pipelined: a new sample accepted every enabled cycle, incl. back-to-back with mode changes.
//  - i_valid==0 samples still propagate data; o_valid=0 for them; consumers ignore o_sum_flat.
//  - Level j adders are DW+j bits wide (sign-extended); no intermediate overflow possible.
//  - i_length_mode > MODE_MAX is clamped to MODE_MAX (o_length_mode reports clamped value).
//  - o_ovf[k]=1 iff exact segment sum > 2^(DW-1)-1 or < -2^(DW-1); unused lanes' o_ovf=0.
// CONFIGURATION
//  ADD_TREE_SAT_EN defined: overflowing sums clamp to 0x7FFF / 0x8000 (DW-generic max/min).
//  Not defined: sums wrap (low DW bits of exact sum). o_ovf behaves identically in both builds.
// STRUCTURE
//  Package add_tree_pkg: sat_to_dw() function, mode_t typedef, default DW/FRAC/SEG_MIN constants.
//  Sub-module add_tree_level #(N,W): N/2 registered pairwise adders W->W+1 with enable/reset;
//  top generates LOG2N instances plus valid/mode/sideband shift registers and output select.
// TESTING
//  1. 64x 0x0100, mode 0 -> seg0 0x4000 (16.0), o_ovf=0, o_valid exactly 8 cycles after input.
//  2. lanes 0..31 0x0100, 32..63 0x0200, mode 1 -> seg0 0x2000, seg1 0x4000, segs 2..3 = 0.
//  3. 64x 0xFF00 (-0.25), mode 2 -> four segs 0xF000 (-4.0); sideband equals input bus.
//  4. 64x 0x0400, mode 0 -> o_ovf[0]=1; SAT_EN: 0x7FFF, else 0x0000.
//  5. Back-to-back modes 0,1,2 then i_en=0 for 3 cycles -> results in order, latency +3, values intact.
//  6. Sample in flight, i_rst=0 one cycle -> all outputs 0, no o_valid; mode 3 input clamped to 2.

Source files
------------

// File: rtl/add_tree_pkg.sv
// Shared types, default constants and overflow/saturation helpers for the segmented adder tree.
package add_tree_pkg;

  localparam int unsigned N_IN_DEF    = 64;
  localparam int unsigned DW_DEF      = 16;
  localparam int unsigned FRAC_DEF    = 10;
  localparam int unsigned SEG_MIN_DEF = 16;
  localparam int unsigned MODE_MAX_DEF = $clog2(N_IN_DEF) - $clog2(SEG_MIN_DEF);
  localparam int unsigned MW_DEF = (MODE_MAX_DEF == 0) ? 1 : $clog2(MODE_MAX_DEF + 1);

  typedef logic [MW_DEF-1:0] mode_t;

  // Exact segment sums are sign-extended to this width before range checks.
  localparam int unsigned XW = 64;
  typedef logic signed [XW-1:0] wide_t;

  function automatic logic is_ovf(input wide_t x, input int unsigned dw);
    wide_t mx;
    wide_t mn;
    mx = (wide_t'(1) <<< (dw - 1)) - wide_t'(1);
    mn = -mx - wide_t'(1);
    return (x > mx) || (x < mn);
  endfunction

  function automatic wide_t sat_to_dw(input wide_t x, input int unsigned dw);
    wide_t mx;
    wide_t mn;
    mx = (wide_t'(1) <<< (dw - 1)) - wide_t'(1);
    mn = -mx - wide_t'(1);
    if (x > mx)      return mx;
    else if (x < mn) return mn;
    else             return x;
  endfunction

endpackage

// File: rtl/add_tree_level.sv
// One registered level of the adder tree: N lanes of W bits -> N/2 sign-extended sums of W+1 bits.
module add_tree_level #(
  parameter int unsigned N = 2,
  parameter int unsigned W = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_en,
  input  logic [N*W-1:0]           i_d,
  output logic [(N/2)*(W+1)-1:0]   o_q
);

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      o_q <= '0;
    end else if (i_en) begin
      for (int unsigned k = 0; k < N/2; k++) begin
        o_q[k*(W+1) +: W+1] <= {i_d[(2*k+1)*W-1], i_d[2*k*W +: W]}
                             + {i_d[(2*k+2)*W-1], i_d[(2*k+1)*W +: W]};
      end
    end
  end

endmodule

// File: rtl/seg_add_tree.sv
// Pipelined segmented signed adder tree with per-segment overflow and aligned sideband.
// Define ADD_TREE_SAT_EN to saturate overflowing sums; otherwise they wrap.
module seg_add_tree
  import add_tree_pkg::*;
#(
  parameter  int unsigned N_IN     = 64,
  parameter  int unsigned DW       = 16,
  parameter  int unsigned FRAC     = 10,
  parameter  int unsigned SEG_MIN  = 16,
  parameter  int unsigned BYP_W    = N_IN*DW,
  localparam int unsigned LOG2N    = $clog2(N_IN),
  localparam int unsigned MODE_MAX = LOG2N - $clog2(SEG_MIN),
  localparam int unsigned NSEG     = N_IN / SEG_MIN,
  localparam int unsigned MW       = (MODE_MAX == 0) ? 1 : $clog2(MODE_MAX + 1)
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_en,
  input  logic                 i_valid,
  input  logic [MW-1:0]        i_length_mode,
  input  logic [N_IN*DW-1:0]   i_in1_flat,
  input  logic [BYP_W-1:0]     i_in0_flat,
  output logic                 o_valid,
  output logic [MW-1:0]        o_length_mode,
  output logic [NSEG*DW-1:0]   o_sum_flat,
  output logic [NSEG-1:0]      o_ovf,
  output logic [BYP_W-1:0]     o_in0_byp
);

  if (((N_IN & (N_IN - 1)) != 0) || ((SEG_MIN & (SEG_MIN - 1)) != 0) ||
      (N_IN < SEG_MIN) || (FRAC >= DW) || (DW + LOG2N > XW)) begin : g_bad_cfg
    $error("seg_add_tree: unsupported parameter set");
  end

  logic [N_IN*DW-1:0] in1_r;
  logic               vld_p  [LOG2N+1];
  logic [MW-1:0]      mode_p [LOG2N+1];
  logic [BYP_W-1:0]   byp_p  [LOG2N+1];
  logic [MW-1:0]      mode_c;

  always_comb begin
    mode_c = (i_length_mode > MW'(MODE_MAX)) ? MW'(MODE_MAX) : i_length_mode;
  end

  // Index i of the side pipes is aligned with tree level i.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      in1_r <= '0;
      for (int unsigned i = 0; i <= LOG2N; i++) begin
        vld_p[i]  <= 1'b0;
        mode_p[i] <= '0;
        byp_p[i]  <= '0;
      end
    end else if (i_en) begin
      in1_r     <= i_in1_flat;
      vld_p[0]  <= i_valid;
      mode_p[0] <= mode_c;
      byp_p[0]  <= i_in0_flat;
      for (int unsigned i = 1; i <= LOG2N; i++) begin
        vld_p[i]  <= vld_p[i-1];
        mode_p[i] <= mode_p[i-1];
        byp_p[i]  <= byp_p[i-1];
      end
    end
  end

  for (genvar j = 0; j <= LOG2N; j++) begin : g_lvl
    logic [(N_IN>>j)*(DW+j)-1:0] q;
    if (j == 0) begin : g_in
      assign q = in1_r;
    end else begin : g_add
      add_tree_level #(.N(N_IN >> (j-1)), .W(DW + j - 1)) u_lvl (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_en  (i_en),
        .i_d   (g_lvl[j-1].q),
        .o_q   (q)
      );
    end
  end

  // Each mode reads its sums from a shallower level; delaying them by the
  // remaining depth keeps every candidate aligned with mode_p[LOG2N].
  logic [NSEG*(DW+1)-1:0] cand_d [MODE_MAX+1];

  for (genvar m = 0; m <= MODE_MAX; m++) begin : g_mode
    localparam int unsigned L  = LOG2N - m;
    localparam int unsigned LW = DW + L;
    localparam int unsigned S  = 1 << m;
    logic [NSEG*(DW+1)-1:0] cand;

    for (genvar s = 0; s < NSEG; s++) begin : g_seg
      if (s < S) begin : g_used
        logic signed [LW-1:0] sum;
        wide_t                x;
        logic [DW-1:0]        res;
        assign sum = g_lvl[L].q[s*LW +: LW];
        assign x   = {{(XW-LW){sum[LW-1]}}, sum};
`ifdef ADD_TREE_SAT_EN
        assign res = DW'(sat_to_dw(x, DW));
`else
        assign res = x[DW-1:0];
`endif
        assign cand[s*(DW+1) +: DW+1] = {is_ovf(x, DW), res};
      end else begin : g_unused
        assign cand[s*(DW+1) +: DW+1] = '0;
      end
    end

    if (m == 0) begin : g_nodly
      assign cand_d[m] = cand;
    end else begin : g_dly
      logic [NSEG*(DW+1)-1:0] dl [m];
      always_ff @(posedge i_clk) begin
        if (!i_rst) begin
          for (int unsigned i = 0; i < m; i++) dl[i] <= '0;
        end else if (i_en) begin
          dl[0] <= cand;
          for (int unsigned i = 1; i < m; i++) dl[i] <= dl[i-1];
        end
      end
      assign cand_d[m] = dl[m-1];
    end
  end

  logic [NSEG*(DW+1)-1:0] sel;

  always_comb begin
    sel = cand_d[mode_p[LOG2N]];
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      o_valid       <= 1'b0;
      o_length_mode <= '0;
      o_sum_flat    <= '0;
      o_ovf         <= '0;
      o_in0_byp     <= '0;
    end else if (i_en) begin
      o_valid       <= vld_p[LOG2N];
      o_length_mode <= mode_p[LOG2N];
      o_in0_byp     <= byp_p[LOG2N];
      for (int unsigned k = 0; k < NSEG; k++) begin
        o_ovf[k]              <= sel[k*(DW+1) + DW];
        o_sum_flat[k*DW +: DW] <= sel[k*(DW+1) +: DW];
      end
    end
  end

endmodule

// File: tb/tb_seg_add_tree.sv
// Scoreboard bench for seg_add_tree: directed vectors queued at issue, checked by a monitor on o_valid.
module tb_seg_add_tree;

  localparam int unsigned N_IN  = 64;
  localparam int unsigned DW    = 16;
  localparam int unsigned NSEG  = 4;
  localparam int unsigned BYP_W = N_IN*DW;
  localparam int unsigned MW    = 2;
  localparam int          LAT   = 8;
`ifdef ADD_TREE_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               i_rst, i_en, i_valid;
  logic [MW-1:0]      i_length_mode;
  logic [N_IN*DW-1:0] i_in1_flat;
  logic [BYP_W-1:0]   i_in0_flat;
  logic               o_valid;
  logic [MW-1:0]      o_length_mode;
  logic [NSEG*DW-1:0] o_sum_flat;
  logic [NSEG-1:0]    o_ovf;
  logic [BYP_W-1:0]   o_in0_byp;

  always #5 clk = ~clk;

  seg_add_tree #(.N_IN(N_IN), .DW(DW), .FRAC(10), .SEG_MIN(16), .BYP_W(BYP_W)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_en(i_en), .i_valid(i_valid),
    .i_length_mode(i_length_mode), .i_in1_flat(i_in1_flat), .i_in0_flat(i_in0_flat),
    .o_valid(o_valid), .o_length_mode(o_length_mode), .o_sum_flat(o_sum_flat),
    .o_ovf(o_ovf), .o_in0_byp(o_in0_byp)
  );

  typedef struct {
    logic [MW-1:0]      mode;
    logic [NSEG*DW-1:0] sum;
    logic [NSEG-1:0]    ovf;
    logic [BYP_W-1:0]   byp;
    int                 stamp;
  } exp_t;

  exp_t               sb[$];
  exp_t               mon_e;
  int                 checks = 0;
  int                 errors = 0;
  int                 en_cnt = 0;
  bit                 edge_en = 1'b0;
  bit                 hold_chk = 1'b0;
  logic [NSEG*DW-1:0] snap_sum;
  logic               snap_vld;
  logic [N_IN*DW-1:0] lanes;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic chk_byp(input string nm, input logic [BYP_W-1:0] act, input logic [BYP_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual_lo=%0h required_lo=%0h", nm, act[63:0], exp[63:0]);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_valid"}, o_valid, 0);
    chk({tag, "_mode"}, o_length_mode, 0);
    chk({tag, "_sum"}, o_sum_flat, 0);
    chk({tag, "_ovf"}, o_ovf, 0);
    chk_byp({tag, "_byp"}, o_in0_byp, '0);
  endtask

  function automatic logic [BYP_W-1:0] pat(input int n);
    logic [BYP_W-1:0] p;
    for (int i = 0; i < BYP_W/32; i++) p[i*32 +: 32] = 32'hC0DE0000 + 32'(n*256 + i);
    return p;
  endfunction

  task automatic fill(input logic [DW-1:0] v);
    for (int k = 0; k < N_IN; k++) lanes[k*DW +: DW] = v;
  endtask

  task automatic issue(input logic [MW-1:0] mode, input bit vld, input logic [BYP_W-1:0] byp,
                       input bit push, input logic [MW-1:0] emode,
                       input logic [NSEG*DW-1:0] esum, input logic [NSEG-1:0] eovf);
    exp_t e;
    @(negedge clk);
    i_en          = 1'b1;
    i_valid       = vld;
    i_length_mode = mode;
    i_in1_flat    = lanes;
    i_in0_flat    = byp;
    if (push) begin
      e.mode  = emode;
      e.sum   = esum;
      e.ovf   = eovf;
      e.byp   = byp;
      e.stamp = en_cnt + LAT;
      sb.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      i_valid = 1'b0;
    end
  endtask

  always @(posedge clk) begin
    edge_en = i_en && i_rst;
    if (edge_en) en_cnt++;
  end

  always @(negedge clk) begin
    if (edge_en && o_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid actual=1 required=0");
      end else begin
        mon_e = sb.pop_front();
        chk("latency", 256'(en_cnt), 256'(mon_e.stamp));
        chk("mode", o_length_mode, mon_e.mode);
        chk("sum", o_sum_flat, mon_e.sum);
        chk("ovf", o_ovf, mon_e.ovf);
        chk_byp("byp", o_in0_byp, mon_e.byp);
      end
    end
    if (hold_chk && !edge_en) begin
      chk("hold_sum", o_sum_flat, snap_sum);
      chk("hold_valid", o_valid, snap_vld);
    end
    snap_sum = o_sum_flat;
    snap_vld = o_valid;
  end

  initial begin
    i_rst = 1'b0; i_en = 1'b0; i_valid = 1'b0; i_length_mode = '0;
    i_in1_flat = '0; i_in0_flat = pat(99); lanes = '0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    i_rst = 1'b1;

    // Single samples across modes, sign and overflow boundaries.
    fill(16'h0100);
    issue(0, 1, pat(1), 1, 0, {16'h0000, 16'h0000, 16'h0000, 16'h4000}, 4'b0000);
    for (int k = 0; k < N_IN; k++) lanes[k*DW +: DW] = (k < 32) ? 16'h0100 : 16'h0200;
    issue(1, 1, pat(2), 1, 1, {16'h0000, 16'h0000, 16'h4000, 16'h2000}, 4'b0000);
    fill(16'hFF00);
    issue(2, 1, lanes, 1, 2, {4{16'hF000}}, 4'b0000);
    fill(16'h1234);
    issue(0, 0, pat(3), 0, 0, '0, '0);
    fill(16'h0400);
    issue(0, 1, pat(4), 1, 0, {16'h0000, 16'h0000, 16'h0000, SAT ? 16'h7FFF : 16'h0000}, 4'b0001);
    fill(16'h8000);
    issue(2, 1, pat(5), 1, 2, {4{SAT ? 16'h8000 : 16'h0000}}, 4'b1111);
    fill(16'h0000);
    lanes[0*DW +: DW]  = 16'h7FFF;
    lanes[16*DW +: DW] = 16'h7FFF;
    lanes[17*DW +: DW] = 16'h0001;
    lanes[32*DW +: DW] = 16'h8000;
    lanes[48*DW +: DW] = 16'h8000;
    lanes[49*DW +: DW] = 16'hFFFF;
    issue(2, 1, pat(6), 1, 2,
          {SAT ? 16'h8000 : 16'h7FFF, 16'h8000, SAT ? 16'h7FFF : 16'h8000, 16'h7FFF}, 4'b1010);
    idle(LAT + 2);

    // Back-to-back mode changes, then a 3-cycle stall with samples in flight.
    fill(16'h0100);
    issue(0, 1, pat(7), 1, 0, {16'h0000, 16'h0000, 16'h0000, 16'h4000}, 4'b0000);
    for (int k = 0; k < N_IN; k++) lanes[k*DW +: DW] = (k < 32) ? 16'h0100 : 16'h0200;
    issue(1, 1, pat(8), 1, 1, {16'h0000, 16'h0000, 16'h4000, 16'h2000}, 4'b0000);
    fill(16'hFF00);
    issue(2, 1, pat(9), 1, 2, {4{16'hF000}}, 4'b0000);
    @(negedge clk);
    i_valid = 1'b0; i_en = 1'b0; hold_chk = 1'b1;
    repeat (3) @(negedge clk);
    i_en = 1'b1; hold_chk = 1'b0;
    idle(LAT + 2);

    // Reset with a sample in flight discards it.
    fill(16'h0100);
    issue(0, 1, pat(10), 0, 0, '0, '0);
    idle(2);
    @(negedge clk);
    i_rst = 1'b0;
    @(negedge clk);
    check_zero("midrst");
    i_rst = 1'b1;
    idle(LAT + 2);

    // Out-of-range mode is clamped to the largest supported one.
    fill(16'hFF00);
    issue(3, 1, pat(11), 1, 2, {4{16'hF000}}, 4'b0000);
    idle(1);
    for (int c = 0; c < 50 && sb.size() != 0; c++) @(negedge clk);
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout actual=%0d required=0", sb.size());
    end
    idle(3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
